// File: rtl/fp16_add_pipe.sv
// Pipelined IEEE 754 binary16 adder: decode, align, add, normalize/round.
// Round to nearest even; operands presented at edge N produce Q at edge N+3.
module fp16_add_pipe (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  input  logic [15:0] OP_A_HALF,
  input  logic [15:0] OP_B_HALF,
  output logic        OUT_VALID,
  output logic [15:0] Q
);

  // ---------------- decode ----------------
  logic [15:0] op_d   [2];
  logic [1:0]  nan_d, inf_d;
  logic [4:0]  exp_d  [2];
  logic [10:0] sig_d  [2];
  logic        spec1_d;
  logic [15:0] specv1_d;

  assign op_d[0] = OP_A_HALF;
  assign op_d[1] = OP_B_HALF;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dec
      assign nan_d[gi] = (&op_d[gi][14:10]) & (|op_d[gi][9:0]);
      assign inf_d[gi] = (&op_d[gi][14:10]) & ~(|op_d[gi][9:0]);
      assign exp_d[gi] = (op_d[gi][14:10] == 5'd0) ? 5'd1 : op_d[gi][14:10];
      assign sig_d[gi] = {|op_d[gi][14:10], op_d[gi][9:0]};
    end
  endgenerate

  // NaN and Inf results bypass the datapath and ride along to the output.
  always_comb begin
    spec1_d  = 1'b1;
    specv1_d = 16'h7E00;
    if (|nan_d)          specv1_d = 16'h7E00;
    else if (&inf_d)     specv1_d = (op_d[0][15] ^ op_d[1][15]) ? 16'h7E00 : op_d[0];
    else if (inf_d[0])   specv1_d = op_d[0];
    else if (inf_d[1])   specv1_d = op_d[1];
    else                 spec1_d  = 1'b0;
  end

  logic        v1_q, spec1_q;
  logic [15:0] specv1_q;
  logic [1:0]  sgn1_q;
  logic [4:0]  exp1_q [2];
  logic [10:0] sig1_q [2];

  always_ff @(posedge CLK) begin
    sgn1_q    <= {OP_B_HALF[15], OP_A_HALF[15]};
    exp1_q[0] <= exp_d[0];
    exp1_q[1] <= exp_d[1];
    sig1_q[0] <= sig_d[0];
    sig1_q[1] <= sig_d[1];
    spec1_q   <= spec1_d;
    specv1_q  <= specv1_d;
  end

  // ---------------- align ----------------
  logic        swap_d, xs2_d, ys2_d;
  logic [4:0]  ex2_d, ey2_d, dist_d;
  logic [10:0] xsig_d, ysig_d;
  logic [13:0] ym_d, ya_d, mask_d;

  always_comb begin
    swap_d = {exp1_q[1], sig1_q[1]} > {exp1_q[0], sig1_q[0]};
    ex2_d  = swap_d ? exp1_q[1] : exp1_q[0];
    ey2_d  = swap_d ? exp1_q[0] : exp1_q[1];
    xsig_d = swap_d ? sig1_q[1] : sig1_q[0];
    ysig_d = swap_d ? sig1_q[0] : sig1_q[1];
    xs2_d  = swap_d ? sgn1_q[1] : sgn1_q[0];
    ys2_d  = swap_d ? sgn1_q[0] : sgn1_q[1];
    dist_d = ex2_d - ey2_d;
    ym_d   = {ysig_d, 3'b000};
    mask_d = 14'd0;
    if (dist_d >= 5'd14) begin
      ya_d = {13'd0, |ysig_d};
    end else begin
      mask_d = (14'd1 << dist_d) - 14'd1;
      ya_d   = ym_d >> dist_d;
      ya_d[0] = ya_d[0] | (|(ym_d & mask_d));
    end
  end

  logic        v2_q, xs2_q, sub2_q, zneg2_q, spec2_q;
  logic [4:0]  exp2_q;
  logic [13:0] xm2_q, ym2_q;
  logic [15:0] specv2_q;

  always_ff @(posedge CLK) begin
    xs2_q    <= xs2_d;
    sub2_q   <= xs2_d ^ ys2_d;
    zneg2_q  <= &sgn1_q;
    exp2_q   <= ex2_d;
    xm2_q    <= {xsig_d, 3'b000};
    ym2_q    <= ya_d;
    spec2_q  <= spec1_q;
    specv2_q <= specv1_q;
  end

  // ---------------- add ----------------
  logic        v3_q, sign3_q, zneg3_q, spec3_q;
  logic [4:0]  exp3_q;
  logic [14:0] sum3_q;
  logic [15:0] specv3_q;

  always_ff @(posedge CLK) begin
    sum3_q   <= sub2_q ? ({1'b0, xm2_q} - {1'b0, ym2_q}) : ({1'b0, xm2_q} + {1'b0, ym2_q});
    sign3_q  <= xs2_q;
    zneg3_q  <= zneg2_q;
    exp3_q   <= exp2_q;
    spec3_q  <= spec2_q;
    specv3_q <= specv2_q;
  end

  // ---------------- normalize / round ----------------
  logic [13:0] m_c, m_n;
  logic [5:0]  e_c, e_m1, sh, e_n, e_r;
  logic [3:0]  lz;
  logic        ru;
  logic [11:0] mant12;
  logic [10:0] man11;
  logic [15:0] res_d;

  always_comb begin
    if (sum3_q[14]) begin
      m_c = {sum3_q[14:2], sum3_q[1] | sum3_q[0]};
      e_c = {1'b0, exp3_q} + 6'd1;
    end else begin
      m_c = sum3_q[13:0];
      e_c = {1'b0, exp3_q};
    end
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (m_c[i]) lz = 4'(13 - i);
    end
    // Left shift stops at exponent 1 so tiny results land as subnormals.
    e_m1 = e_c - 6'd1;
    sh   = ({2'b00, lz} < e_m1) ? {2'b00, lz} : e_m1;
    m_n  = m_c << sh;
    e_n  = e_c - sh;
    ru     = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    mant12 = {1'b0, m_n[13:3]} + {11'd0, ru};
    if (mant12[11]) begin
      man11 = mant12[11:1];
      e_r   = e_n + 6'd1;
    end else begin
      man11 = mant12[10:0];
      e_r   = e_n;
    end
    if (spec3_q)               res_d = specv3_q;
    else if (sum3_q == 15'd0)  res_d = {zneg3_q, 15'd0};
    else if (e_r >= 6'd31)     res_d = {sign3_q, 5'h1F, 10'd0};
    else                       res_d = {sign3_q, (man11[10] ? e_r[4:0] : 5'd0), man11[9:0]};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      OUT_VALID <= 1'b0;
      Q         <= 16'h0000;
    end else begin
      v1_q      <= IN_VALID;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      OUT_VALID <= v3_q;
      if (v3_q) Q <= res_d;
    end
  end

endmodule

// File: tb/tb_fp16_add_pipe.sv
// Bench for fp16_add_pipe: directed table, streaming, reset flush and random
// operands checked against an exact-arithmetic rounding model.
module tb_fp16_add_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic [15:0] OP_A_HALF, OP_B_HALF;
  logic        OUT_VALID;
  logic [15:0] Q;

  fp16_add_pipe dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .OP_A_HALF (OP_A_HALF),
    .OP_B_HALF (OP_B_HALF),
    .OUT_VALID (OUT_VALID),
    .Q         (Q)
  );

  always #5 CLK = ~CLK;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic        v;
    logic [15:0] a, b, q;
  } ent_t;

  ent_t        exp_fifo[$];
  logic [15:0] hold_q;

  logic [15:0] da [15] = '{16'h3C00, 16'h3C00, 16'h4200, 16'h3C00, 16'h8000,
                           16'h0000, 16'h3C00, 16'h3C01, 16'h3C00, 16'h0001,
                           16'h03FF, 16'h7BFF, 16'h7C00, 16'h7E01, 16'hFC00};
  logic [15:0] db [15] = '{16'h3C00, 16'h3800, 16'hBC00, 16'hBC00, 16'h8000,
                           16'h8000, 16'h1000, 16'h1000, 16'h0001, 16'h0001,
                           16'h0001, 16'h7BFF, 16'hFC00, 16'h3C00, 16'h3C00};
  logic [15:0] dq [15] = '{16'h4000, 16'h3E00, 16'h4000, 16'h0000, 16'h8000,
                           16'h0000, 16'h3C00, 16'h3C02, 16'h3C00, 16'h0002,
                           16'h0400, 16'h7C00, 16'h7E00, 16'h7E00, 16'hFC00};

  // Magnitude of a finite half in units of 2^-24 (exact).
  function automatic longint mag_of(input logic [15:0] h);
    int e;
    e = int'(h[14:10]);
    if (e == 0) return longint'(h[9:0]);
    return longint'(1024 + int'(h[9:0])) << (e - 1);
  endfunction

  // Exact sum, then round-to-nearest-even into binary16.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic   an, bn, ai, bi, sgn;
    longint s, mag, qv, rem, half;
    int     p, sh;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (an || bn) return 16'h7E00;
    if (ai && bi) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (ai) return a;
    if (bi) return b;
    s = (a[15] ? -mag_of(a) : mag_of(a)) + (b[15] ? -mag_of(b) : mag_of(b));
    if (s == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    if (mag < 2048) return {sgn, mag[14:0]};
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    sh   = p - 10;
    qv   = mag >> sh;
    rem  = mag - (qv << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && qv[0])) qv = qv + 1;
    if (qv == 2048) begin
      qv = 1024;
      sh = sh + 1;
    end
    if (sh + 1 >= 31) return {sgn, 15'h7C00};
    return {sgn, 5'(sh + 1), 10'(qv - 1024)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock with the given inputs; checks the slot issued three edges earlier.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expq);
    ent_t e, o;
    logic ev;
    IN_VALID  = v;
    OP_A_HALF = a;
    OP_B_HALF = b;
    @(posedge CLK);
    #1;
    e.v = v; e.a = a; e.b = b; e.q = expq;
    exp_fifo.push_back(e);
    ev = 1'b0;
    o  = e;
    if (exp_fifo.size() > 3) begin
      o  = exp_fifo.pop_front();
      ev = o.v;
    end
    check("out_valid", {15'd0, OUT_VALID}, {15'd0, ev});
    if (ev) begin
      hold_q = o.q;
      $display("txn %h + %h -> %h (expected %h)", o.a, o.b, Q, o.q);
      check($sformatf("sum %h+%h", o.a, o.b), Q, hold_q);
    end else begin
      check("q_hold", Q, hold_q);
    end
  endtask

  task automatic rst_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      RST_N     = 1'b0;
      IN_VALID  = 1'b1;
      OP_A_HALF = 16'h3C00;
      OP_B_HALF = 16'h3C00;
      @(posedge CLK);
      #1;
      exp_fifo.delete();
      hold_q = 16'h0000;
      check("rst_out_valid", {15'd0, OUT_VALID}, 16'd0);
      check("rst_q", Q, 16'h0000);
    end
    RST_N = 1'b1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 3))
      0: r[14:10] = 5'(($urandom_range(0, 2)));
      1: r[14:10] = 5'(($urandom_range(12, 18)));
      2: r[14:10] = 5'(($urandom_range(28, 30)));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [15:0] a, b;
    logic        v;
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    OP_A_HALF = 16'h0000;
    OP_B_HALF = 16'h0000;
    hold_q    = 16'h0000;
    rst_cycles(2);

    // directed table, one operation at a time
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, da[i], db[i], dq[i]);
      repeat (3) cycle(1'b0, 16'($urandom), 16'($urandom), 16'h0000);
    end

    // back-to-back stream
    for (int i = 0; i < 5; i++) cycle(1'b1, da[i], db[i], dq[i]);
    repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);

    // reset with two operations in flight
    cycle(1'b1, 16'h3C00, 16'h3C00, 16'h4000);
    cycle(1'b1, 16'h3C00, 16'h3800, 16'h3E00);
    rst_cycles(1);
    cycle(1'b1, 16'h4200, 16'hBC00, 16'h4000);
    repeat (5) cycle(1'b0, 16'h3C00, 16'h3C00, 16'h0000);

    // randomized operands against the reference model
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = rand_op();
      b = rand_op();
      if ($urandom_range(0, 4) == 0) b = {~a[15], a[14:3], 3'($urandom)};
      cycle(v, a, b, ref_add(a, b));
    end
    repeat (4) cycle(1'b0, 16'h0000, 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_add_pipe.md
# fp16_add_pipe

Pipelined IEEE 754 binary16 (half-precision) adder. It takes two FP16 operands per cycle and returns their rounded sum a fixed three cycles later. Internally it is a decode stage, an exponent-align stage, a mantissa add stage and a normalize/round stage. It is the registered, sign-correct, rounding version of the team's combinational half-precision adder datapath, intended for the FPU pipeline.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock; the only clock.
- RST_N  in  1  synchronous reset, active-low, sampled on the CLK rising edge.
- IN_VALID  in  1  OP_A_HALF/OP_B_HALF carry an operation this cycle.
- OP_A_HALF  in  16  operand A: {sign, exp[4:0], mant[9:0]}.
- OP_B_HALF  in  16  operand B, same format.
- OUT_VALID  out  1  Q carries a result this cycle.
- Q  out  16  FP16 sum A+B.

## Operation
- Decode:
  - sign = bit15, exp = bits14:10, mant = bits9:0.
  - exp=0: hidden bit 0, effective exponent 1 (zero/subnormal).
  - exp 1..30: hidden bit 1.
  - exp=31: mant=0 is Inf, mant≠0 is NaN.
- Align:
  - Build a 14-bit extended mantissa per operand: {hidden, mant[9:0], G, R, S}, with G=R=S=0 initially.
  - Swap so the larger magnitude is operand X (compare {exp,mant}).
  - Shift Y right by d = expX − expY. Bits shifted past S are OR-ed into S (sticky).
  - d ≥ 14: Y becomes 0 with S = (Y≠0).
  - Common exponent = expX.
- Sum (15-bit):
  - Signs equal: X+Y, carry lands in bit14.
  - Signs differ: X−Y, result never negative.
  - Result sign = sign of X.
- Normalize:
  - Carry set: shift right 1 with sticky, exponent+1.
  - Otherwise: shift left until hidden bit is set or exponent reaches 1. Exponent 1 with hidden 0 encodes as exp field 0 (subnormal).
- Round to nearest, ties to even, on the bits G, R and S.
  - A mantissa carry out of rounding increments the exponent.
  - exp ≥ 31 after rounding → ±Inf (sign, 0x1F, 0).
- Specials, which take priority over the datapath:
  - Either operand NaN → 0x7E00 (canonical quiet NaN).
  - +Inf + −Inf → 0x7E00.
  - Inf + finite, or Inf + same-sign Inf → that Inf.
  - Exact zero result: +0 (0x0000), except −0 + −0 → 0x8000.

## Timing
- Three register stages; latency 3.
  - Operands sampled at edge N.
  - Q and OUT_VALID updated at edge N+3.
- Throughput one operation per cycle. No stall or backpressure.
- OUT_VALID is IN_VALID delayed by 3 cycles.
- With IN_VALID=0, the data path may still advance, but OUT_VALID=0 for that slot. Q holds its last value while OUT_VALID=0.
- Reset (RST_N=0 at an edge):
  - Q=0x0000, OUT_VALID=0, all internal valid bits cleared.
  - Operations in flight are discarded; nothing emerges after reset.
- First valid result after reset release: an operation presented at edge N (RST_N=1) appears at edge N+3.
- Back-to-back operations must not interfere. Each result depends only on its own operands.

## Test plan
- Basic adds, each after a 3-cycle latency:
  - 0x3C00 + 0x3C00 → 0x4000.
  - 0x3C00 + 0x3800 → 0x3E00.
  - 0x4200 + 0xBC00 → 0x4000.
- Cancellation and zero signs:
  - 0x3C00 + 0xBC00 → 0x0000.
  - 0x8000 + 0x8000 → 0x8000.
  - 0x0000 + 0x8000 → 0x0000.
- Rounding:
  - 0x3C00 + 0x1000 (tie) → 0x3C00 (even).
  - 0x3C01 + 0x1000 → 0x3C02.
  - 0x3C00 + 0x0001 (sticky only) → 0x3C00.
- Subnormal/overflow:
  - 0x0001 + 0x0001 → 0x0002.
  - 0x03FF + 0x0001 → 0x0400.
  - 0x7BFF + 0x7BFF → 0x7C00.
- Specials:
  - 0x7C00 + 0xFC00 → 0x7E00.
  - 0x7E01 + 0x3C00 → 0x7E00.
  - 0xFC00 + 0x3C00 → 0xFC00.
- Pipeline:
  - Stream 5 back-to-back operations with IN_VALID=1: results appear in order on 5 consecutive cycles.
  - Assert RST_N=0 with 2 operations in flight: Q=0, OUT_VALID=0, and neither result ever appears.
